// File: rtl/weight_fetch_pkg.sv
// -----------------------------------------------------------------------------
// weight_fetch_pkg
// Shared definitions for the weight fetch scheduler:
//   - state_e       : scheduler FSM states (IDLE, STREAM)
//   - DEF_*         : default parameter values for the scheduler and arbiter
// -----------------------------------------------------------------------------
package weight_fetch_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_MEMORY_WIDTH = 72;
  localparam int DEF_ADDRS_WIDTH  = 8;
  localparam int DEF_LEN_WIDTH    = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/weight_fetch_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a one-hot grant. The grant is combinational from
// req_i and the priority pointer; the pointer moves to (grant index + 1) on
// every cycle adv_i is high.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset (pointer -> 0)
//   req_i          : request lines, one per requester
//   adv_i          : advance the pointer past the current grant
//   grant_o        : one-hot grant (all zero when nobody requests)
//   grant_idx_o    : binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
  import weight_fetch_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               found_s;
  logic [31:0]        idx_s;

  // Pick the first requesting line at or after the pointer, wrapping around.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {IDX_W{1'b0}};
    found_s     = 1'b0;
    idx_s       = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = (32'(ptr_r) + 32'(i)) % 32'(NUM_REQ);
      if (!found_s && req_i[idx_s[IDX_W-1:0]]) begin
        grant_s[idx_s[IDX_W-1:0]] = 1'b1;
        grant_idx_s               = idx_s[IDX_W-1:0];
        found_s                   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Move the priority pointer to one past the requester just served.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (adv_i) begin
      if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
        ptr_r <= {IDX_W{1'b0}};
      end else begin
        ptr_r <= grant_idx_s + IDX_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant_o     = grant_s;
  assign grant_idx_o = grant_idx_s;

endmodule

// File: rtl/weight_fetch_sched.sv
// -----------------------------------------------------------------------------
// weight_fetch_sched
// Shares one combinational weight ROM between NUM_REQ burst requesters.
// A requester is granted round-robin while idle; its burst (base, len+1 beats)
// is then read one word per cycle and streamed out through a single output
// register with valid/ready handshake.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   req_valid_i/ready_o   : per-requester burst handshake (ready is one-hot)
//   req_base_i, req_len_i : packed start address / beat count minus one
//   addrs_mem_o, rd_mem_ld_o, mem_data_i : ROM port (data valid same cycle)
//   data_o, data_valid_o, data_id_o, data_last_o, data_ready_i : beat stream
//   busy_o                : burst active or beat pending
//   beat_cnt_o            : delivered-beat counter
// Optional feature: define WFS_BEAT_CNT_EN to build the 32-bit beat counter;
// otherwise beat_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module weight_fetch_sched
  import weight_fetch_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
  parameter int ADDRS_WIDTH  = DEF_ADDRS_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*ADDRS_WIDTH-1:0] req_base_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len_i,
  output logic [ADDRS_WIDTH-1:0]         addrs_mem_o,
  output logic                           rd_mem_ld_o,
  input  logic [MEMORY_WIDTH-1:0]        mem_data_i,
  output logic [MEMORY_WIDTH-1:0]        data_o,
  output logic                           data_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]     data_id_o,
  output logic                           data_last_o,
  input  logic                           data_ready_i,
  output logic                           busy_o,
  output logic [31:0]                    beat_cnt_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                  state_r;
  logic [ADDRS_WIDTH-1:0]  addr_r;
  logic [LEN_WIDTH-1:0]    rem_r;
  logic [ID_W-1:0]         id_r;
  logic [MEMORY_WIDTH-1:0] data_r;
  logic                    data_valid_r;
  logic [ID_W-1:0]         data_id_r;
  logic                    data_last_r;

  logic [NUM_REQ-1:0]      grant_s;
  logic [ID_W-1:0]         grant_idx_s;
  logic [NUM_REQ-1:0]      ready_s;
  logic                    accept_s;
  logic                    issue_s;
  logic [ADDRS_WIDTH-1:0]  sel_base_s;
  logic [LEN_WIDTH-1:0]    sel_len_s;
  logic [ADDRS_WIDTH-1:0]  addrs_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_valid_i),
    .adv_i       (accept_s),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s)
  );

  // Grants are only offered while idle; a read is only issued when the output
  // register is free this cycle, so a stalled beat is never overwritten.
  always_comb begin
    if (state_r == IDLE) begin
      ready_s = grant_s;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
    accept_s   = |(req_valid_i & ready_s);
    issue_s    = (state_r == STREAM) && (!data_valid_r || data_ready_i);
    sel_base_s = req_base_i[int'(grant_idx_s)*ADDRS_WIDTH +: ADDRS_WIDTH];
    sel_len_s  = req_len_i[int'(grant_idx_s)*LEN_WIDTH +: LEN_WIDTH];
    if (issue_s) begin
      addrs_s = addr_r;
    end else begin
      addrs_s = {ADDRS_WIDTH{1'b0}};
    end
  end

  // Burst FSM: latch the granted request, then walk the address range.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      addr_r  <= {ADDRS_WIDTH{1'b0}};
      rem_r   <= {LEN_WIDTH{1'b0}};
      id_r    <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= sel_base_s;
            rem_r   <= sel_len_s;
            id_r    <= grant_idx_s;
            state_r <= STREAM;
          end else begin
            state_r <= IDLE;
          end
        end
        STREAM: begin
          if (issue_s) begin
            // Address naturally wraps modulo 2^ADDRS_WIDTH.
            addr_r <= addr_r + ADDRS_WIDTH'(1);
            rem_r  <= rem_r - LEN_WIDTH'(1);
            if (rem_r == {LEN_WIDTH{1'b0}}) begin
              state_r <= IDLE;
            end else begin
              state_r <= STREAM;
            end
          end else begin
            state_r <= STREAM;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output beat register: load on each read, empty when drained without refill.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_r       <= {MEMORY_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      data_id_r    <= {ID_W{1'b0}};
      data_last_r  <= 1'b0;
    end else if (issue_s) begin
      data_r       <= mem_data_i;
      data_valid_r <= 1'b1;
      data_id_r    <= id_r;
      data_last_r  <= (rem_r == {LEN_WIDTH{1'b0}});
    end else if (data_ready_i) begin
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= data_valid_r;
    end
  end

`ifdef WFS_BEAT_CNT_EN
  logic [31:0] beat_cnt_r;

  // Count every delivered beat; wraps at 2^32.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_cnt_r <= 32'd0;
    end else if (data_valid_r && data_ready_i) begin
      beat_cnt_r <= beat_cnt_r + 32'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt_o = beat_cnt_r;
`else
  assign beat_cnt_o = 32'd0;
`endif

  assign req_ready_o  = ready_s;
  assign rd_mem_ld_o  = issue_s;
  assign addrs_mem_o  = addrs_s;
  assign data_o       = data_r;
  assign data_valid_o = data_valid_r;
  assign data_id_o    = data_id_r;
  assign data_last_o  = data_last_r;
  assign busy_o       = (state_r == STREAM) || data_valid_r;

endmodule

// File: tb/tb_weight_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_sched
// Self-checking bench for weight_fetch_sched (default parameters). A
// transaction-level model (queue of outstanding reads, one pending beat,
// round-robin pointer) is compared against the DUT every cycle; directed
// scenarios additionally pin exact addresses, grant order and latencies.
// -----------------------------------------------------------------------------
module tb_weight_fetch_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_base;
  logic [31:0] req_len;
  logic [7:0]  addrs;
  logic        rd;
  logic [71:0] mem_data;
  logic [71:0] data;
  logic        data_valid;
  logic [1:0]  data_id;
  logic        data_last;
  logic        data_ready;
  logic        busy;
  logic [31:0] beat_cnt;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;
  int cyc   = 0;

  weight_fetch_sched dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_base_i   (req_base),
    .req_len_i    (req_len),
    .addrs_mem_o  (addrs),
    .rd_mem_ld_o  (rd),
    .mem_data_i   (mem_data),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_id_o    (data_id),
    .data_last_o  (data_last),
    .data_ready_i (data_ready),
    .busy_o       (busy),
    .beat_cnt_o   (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] rom(input logic [7:0] a);
    return {a ^ 8'h5A, {8{a}} ^ 64'h0123_4567_89AB_CDEF};
  endfunction

  assign mem_data = rom(addrs);

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] id;
    logic       last;
  } rd_t;

  rd_t         addrq[$];
  logic        pend_m = 1'b0;
  logic [71:0] bdata_m;
  logic [1:0]  bid_m;
  logic        blast_m;
  int          ptr_m = 0;
  logic [31:0] cnt_m = 32'd0;

  // logs of what the DUT actually did (for directed literal checks)
  int          acc_g[$];
  int          acc_c[$];
  logic [7:0]  rd_a[$];
  int          rd_c[$];
  logic [71:0] bt_d[$];
  logic [1:0]  bt_id[$];
  logic        bt_last[$];
  int          bt_c[$];

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int         g;
    int         lenv;
    logic [7:0] b;
    logic [3:0] eg;
    logic       erd;
    logic [7:0] ea;
    rd_t        r;
    cyc++;
    if (!rst_n) begin
      addrq.delete();
      pend_m = 1'b0;
      ptr_m  = 0;
      cnt_m  = 32'd0;
    end else begin
      eg = 4'b0000;
      g  = -1;
      if (addrq.size() == 0) begin
        g = rr_pick(req_valid, ptr_m);
        if (g >= 0) eg[g] = 1'b1;
      end
      erd = (addrq.size() > 0) && (!pend_m || data_ready);
      ea  = erd ? addrq[0].addr : 8'h00;
      chk("req_ready", 72'(req_ready), 72'(eg));
      chk("rd_mem_ld", 72'(rd), 72'(erd));
      chk("addrs_mem", 72'(addrs), 72'(ea));
      chk("data_valid", 72'(data_valid), 72'(pend_m));
      chk("busy", 72'(busy), 72'((addrq.size() > 0) || pend_m));
      chk("beat_cnt", 72'(beat_cnt), 72'(cnt_m));
      if (pend_m) begin
        chk("data", data, bdata_m);
        chk("data_id", 72'(data_id), 72'(bid_m));
        chk("data_last", 72'(data_last), 72'(blast_m));
      end
      // DUT activity logs
      for (int k = 0; k < 4; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          acc_g.push_back(k);
          acc_c.push_back(cyc);
        end
      end
      if (rd) begin
        rd_a.push_back(addrs);
        rd_c.push_back(cyc);
      end
      if (data_valid && data_ready) begin
        bt_d.push_back(data);
        bt_id.push_back(data_id);
        bt_last.push_back(data_last);
        bt_c.push_back(cyc);
      end
      // advance the model across the coming edge
      if (pend_m && data_ready) begin
        pend_m = 1'b0;
`ifdef WFS_BEAT_CNT_EN
        cnt_m = cnt_m + 32'd1;
`endif
      end
      if (erd) begin
        r       = addrq.pop_front();
        bdata_m = rom(r.addr);
        bid_m   = r.id;
        blast_m = r.last;
        pend_m  = 1'b1;
      end
      if (g >= 0) begin
        b    = req_base[g*8 +: 8];
        lenv = int'(req_len[g*8 +: 8]);
        for (int j = 0; j <= lenv; j++) begin
          addrq.push_back('{addr: b + 8'(j), id: 2'(g), last: (j == lenv)});
        end
        ptr_m = (g + 1) % 4;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       data_ready = 1'b1;
        1:       data_ready = ~data_ready;
        default: data_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input int k, input logic [7:0] b, input logic [7:0] l);
    int t;
    logic got;
    req_base[k*8 +: 8] = b;
    req_len[k*8 +: 8]  = l;
    req_valid[k]       = 1'b1;
    t   = 0;
    got = 1'b0;
    while (!got && t < 50) begin
      @(negedge clk);
      got = req_ready[k];
      t++;
    end
    chk("grant_wait", 72'(got), 72'd1);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 72'(busy), 72'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tg);
    chk({tg, "_req_ready"}, 72'(req_ready), 72'd0);
    chk({tg, "_rd"}, 72'(rd), 72'd0);
    chk({tg, "_addrs"}, 72'(addrs), 72'd0);
    chk({tg, "_dvalid"}, 72'(data_valid), 72'd0);
    chk({tg, "_data"}, data, 72'd0);
    chk({tg, "_did"}, 72'(data_id), 72'd0);
    chk({tg, "_dlast"}, 72'(data_last), 72'd0);
    chk({tg, "_busy"}, 72'(busy), 72'd0);
    chk({tg, "_beat_cnt"}, 72'(beat_cnt), 72'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic check_burst(input string tg, input int s_rd, input int s_bt,
                             input logic [7:0] base, input int len, input int id);
    logic [7:0] a;
    chk({tg, "_nreads"}, 72'(rd_a.size() - s_rd), 72'(len + 1));
    chk({tg, "_nbeats"}, 72'(bt_d.size() - s_bt), 72'(len + 1));
    for (int i = 0; i <= len; i++) begin
      a = base + 8'(i);
      if (s_rd + i < rd_a.size()) chk({tg, "_addr"}, 72'(rd_a[s_rd + i]), 72'(a));
      if (s_bt + i < bt_d.size()) begin
        chk({tg, "_bdata"}, bt_d[s_bt + i], rom(a));
        chk({tg, "_bid"}, 72'(bt_id[s_bt + i]), 72'(id));
        chk({tg, "_blast"}, 72'(bt_last[s_bt + i]), 72'(i == len));
      end
    end
  endtask

  initial begin
    int s_rd;
    int s_bt;
    int s_acc;
    int t;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_base  = 32'd0;
    req_len   = 32'd0;
    tick(2);
    chk_zero("por");
    rst_n = 1'b1;
    tick(1);

    // single burst: req 0, base 0x10, len 3
    s_rd = rd_a.size(); s_bt = bt_d.size(); s_acc = acc_g.size();
    request(0, 8'h10, 8'd3);
    wait_idle();
    check_burst("single", s_rd, s_bt, 8'h10, 3, 0);
    chk("single_addr0", 72'(rd_a[s_rd]), 72'h10);
    chk("single_addr3", 72'(rd_a[s_rd + 3]), 72'h13);
    if (acc_c.size() > s_acc && rd_c.size() > s_rd + 3 && bt_c.size() > s_bt) begin
      chk("single_rd_lat", 72'(rd_c[s_rd] - acc_c[s_acc]), 72'd1);
      chk("single_rd_span", 72'(rd_c[s_rd + 3] - rd_c[s_rd]), 72'd3);
      chk("single_beat_lat", 72'(bt_c[s_bt] - acc_c[s_acc]), 72'd2);
    end else begin
      chk("single_logs", 72'd0, 72'd1);
    end

    // arbitration: all four requesting continuously, len 0
    reset_pulse();
    s_acc = acc_g.size();
    for (int k = 0; k < 4; k++) begin
      req_base[k*8 +: 8] = 8'(8'h30 + 8'(k * 16));
      req_len[k*8 +: 8]  = 8'd0;
    end
    req_valid = 4'hF;
    t = 0;
    while (acc_g.size() - s_acc < 5 && t < 100) begin
      tick(1);
      t++;
    end
    req_valid = 4'h0;
    chk("arb_count", 72'(acc_g.size() - s_acc >= 5), 72'd1);
    for (int i = 0; i < 5; i++) begin
      if (s_acc + i < acc_g.size()) chk("arb_order", 72'(acc_g[s_acc + i]), 72'(i % 4));
    end
    wait_idle();

    // backpressure: len 7, data_ready toggling
    mode = 1;
    s_rd = rd_a.size(); s_bt = bt_d.size();
    request(2, 8'h40, 8'd7);
    wait_idle();
    mode = 0;
    tick(1);
    check_burst("bp", s_rd, s_bt, 8'h40, 7, 2);

    // address wrap: base 0xFE, len 2
    s_rd = rd_a.size(); s_bt = bt_d.size();
    request(1, 8'hFE, 8'd2);
    wait_idle();
    check_burst("wrap", s_rd, s_bt, 8'hFE, 2, 1);
    if (rd_a.size() > s_rd + 2) begin
      chk("wrap_a1", 72'(rd_a[s_rd + 1]), 72'hFF);
      chk("wrap_a2", 72'(rd_a[s_rd + 2]), 72'h00);
    end

    // reset during beat 3 of an 8-beat burst
    s_bt = bt_d.size();
    request(3, 8'h80, 8'd7);
    t = 0;
    while (!((bt_d.size() - s_bt == 2) && data_valid) && t < 50) begin
      tick(1);
      t++;
    end
    chk("rst_reach_beat3", 72'(data_valid), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    s_rd = rd_a.size(); s_bt = bt_d.size();
    request(0, 8'h20, 8'd1);
    wait_idle();
    check_burst("postrst", s_rd, s_bt, 8'h20, 1, 0);

    // beat counter: bursts of 4 and 2 beats
    reset_pulse();
    request(0, 8'h00, 8'd3);
    wait_idle();
    request(1, 8'h50, 8'd1);
    wait_idle();
`ifdef WFS_BEAT_CNT_EN
    chk("beat_cnt_6", 72'(beat_cnt), 72'd6);
`else
    chk("beat_cnt_off", 72'(beat_cnt), 72'd0);
`endif

    // randomized traffic with random backpressure
    mode = 2;
    for (int i = 0; i < 600; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        req_base[k*8 +: 8] = 8'($urandom_range(0, 255));
        req_len[k*8 +: 8]  = 8'($urandom_range(0, 5));
      end
      tick(1);
    end
    req_valid = 4'h0;
    mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_fetch_sched.md
WEIGHT_FETCH_SCHED -- requirements
Module: weight_fetch_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one weight ROM.
REQ-002 SHALL have parameter MEMORY_WIDTH, default 72: ROM word width.
REQ-003 SHALL have parameter ADDRS_WIDTH, default 8: ROM address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8: burst-length field width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock (rising edge); rst_n_i  in  1  reset.
REQ-006 SHALL have port req_valid_i  in  NUM_REQ: per-requester burst request.
REQ-007 SHALL have port req_ready_o  out  NUM_REQ: one-hot grant; a request is accepted on valid&ready.
REQ-008 SHALL have port req_base_i  in  NUM_REQ*ADDRS_WIDTH: packed start addresses, requester k at slice k.
REQ-009 SHALL have port req_len_i  in  NUM_REQ*LEN_WIDTH: packed beat count minus one.
REQ-010 SHALL have port addrs_mem_o  out  ADDRS_WIDTH: ROM address.
REQ-011 SHALL have port rd_mem_ld_o  out  1: ROM read enable; ROM data is combinational and valid in the same cycle.
REQ-012 SHALL have port mem_data_i  in  MEMORY_WIDTH: ROM read data.
REQ-013 SHALL have ports data_o  out  MEMORY_WIDTH, data_valid_o  out  1, data_id_o  out  $clog2(NUM_REQ), data_last_o  out  1, data_ready_i  in  1: output beat stream with valid/ready.
REQ-014 SHALL have port busy_o  out  1: high while any burst is active or any beat is pending.
REQ-015 SHALL have port beat_cnt_o  out  32: delivered-beat counter (see Configuration).

Function
REQ-016 SHALL use FSM states IDLE and STREAM; IDLE->STREAM on acceptance; STREAM->IDLE in the cycle the last ROM read issues.
REQ-017 SHALL assert req_ready_o only in IDLE, granting exactly one valid requester by round-robin; the priority pointer moves to grant+1 after each acceptance.
REQ-018 SHALL latch the base address, length and id on acceptance; later changes on req_* SHALL not affect an active burst.
REQ-019 SHALL issue the first read (rd_mem_ld_o=1, addrs_mem_o=base) one cycle after acceptance, then base+1 ... base+len, one per cycle when not stalled.
REQ-020 SHALL wrap addresses modulo 2^ADDRS_WIDTH (base 0xFF, len 1 -> 0xFF, 0x00).
REQ-021 SHALL register mem_data_i into data_o on every read, so data_valid_o rises one cycle after the corresponding read (two cycles after acceptance).
REQ-022 SHALL assert rd_mem_ld_o only when the output register is empty or is being drained (data_ready_i=1) that cycle; otherwise address and read are held, with no beat lost or duplicated.
REQ-023 SHALL hold data_o, data_id_o and data_last_o stable while data_valid_o=1 and data_ready_i=0.
REQ-024 SHALL assert data_last_o on the beat of read len.
REQ-025 SHALL drive rd_mem_ld_o=0 and addrs_mem_o=0 when no read is issued.
REQ-026 SHALL allow a new acceptance in the cycle after the last read, while the last beat is still pending; no idle gap is required between bursts.
REQ-027 SHALL keep busy_o=0 only when in IDLE and data_valid_o=0.

Reset
REQ-028 SHALL on rst_n_i low, asynchronously: state IDLE, req_ready_o 0, rd_mem_ld_o 0, addrs_mem_o 0, data_valid_o 0, data_o 0, data_id_o 0, data_last_o 0, busy_o 0, beat_cnt_o 0, RR pointer 0.
REQ-029 SHALL abort any burst on mid-burst reset; outstanding beats are discarded and are not replayed.

Configuration
REQ-030 SHALL compile a 32-bit beat counter only under macro WFS_BEAT_CNT_EN: it increments on each data_valid_o&data_ready_i and wraps at 2^32; without the macro, beat_cnt_o SHALL be constant 0 and no counter logic is present.

Structure
REQ-031 SHALL use package weight_fetch_pkg for the state enum (IDLE, STREAM) and the default width constants.
REQ-032 SHALL use one sub-module, rr_arbiter (NUM_REQ-wide, one-hot grant, pointer advanced by an enable input).

Verification
REQ-033 SHALL verify single burst: req 0, base 0x10, len 3, data_ready_i=1 -> reads at 0x10-0x13 in 4 consecutive cycles; 4 beats, id 0, last on 4th; first beat 2 cycles after acceptance.
REQ-034 SHALL verify arbitration: all 4 requesters valid continuously with len 0 -> grants in order 0,1,2,3,0; each requester granted exactly once per 4 bursts.
REQ-035 SHALL verify backpressure: len 7 with data_ready_i toggling 1/0 -> 8 beats in address order, none duplicated, data stable during stalls.
REQ-036 SHALL verify wrap: base 0xFE, len 2 -> addresses 0xFE, 0xFF, 0x00.
REQ-037 SHALL verify reset: rst_n_i low during beat 3 of an 8-beat burst -> all outputs 0 immediately; a new burst after reset completes normally.
REQ-038 SHALL verify the counter with WFS_BEAT_CNT_EN: after bursts of 4 and 2 beats, beat_cnt_o=6; without the macro, beat_cnt_o=0.
